// File: rtl/alu_issue_seq_pkg.sv
// Shared definitions for the ALU issue/sequencing stage.
//   op_e    : request opcodes (0sss = plain ALU select sss, 1000 = MUL, rest reserved)
//   sel_e   : select encodings understood by the datapath ALU
//   state_e : sequencer states
package alu_issue_seq_pkg;

  typedef enum logic [3:0] {
    OP_PASSA = 4'b0000,
    OP_INC   = 4'b0001,
    OP_ADD   = 4'b0010,
    OP_SUB   = 4'b0011,
    OP_AND   = 4'b0100,
    OP_OR    = 4'b0101,
    OP_DEC   = 4'b0110,
    OP_PASSB = 4'b0111,
    OP_MUL   = 4'b1000
  } op_e;

  typedef enum logic [2:0] {
    SEL_PASSA = 3'b000,
    SEL_INC   = 3'b001,
    SEL_ADD   = 3'b010,
    SEL_SUB   = 3'b011,
    SEL_AND   = 3'b100,
    SEL_OR    = 3'b101,
    SEL_DEC   = 3'b110,
    SEL_PASSB = 3'b111
  } sel_e;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    EXEC = 2'd1,
    MUL  = 2'd2,
    DONE = 2'd3
  } state_e;

  // Opcodes 1001..1111 have no meaning and are answered with out_err.
  function automatic logic is_reserved(input logic [3:0] op);
    return op[3] && (op[2:0] != 3'b000);
  endfunction

endpackage

// File: rtl/alu_issue_seq_if.sv
// Request/response handshake bundle of the ALU issue stage.
//   in_*  : request channel (valid/ready, opcode, two operands)
//   out_* : response channel (valid/ready, 2*WIDTH result, carry, error flag)
// Modports: master = requester/consumer side, slave = the issue stage.
interface alu_issue_seq_if #(
  parameter int WIDTH = 8
) ();

  logic               in_valid;
  logic               in_ready;
  logic [3:0]         in_op;
  logic [WIDTH-1:0]   in_a;
  logic [WIDTH-1:0]   in_b;
  logic               out_valid;
  logic               out_ready;
  logic [2*WIDTH-1:0] out_result;
  logic               out_carry;
  logic               out_err;

  modport master (
    output in_valid, in_op, in_a, in_b, out_ready,
    input  in_ready, out_valid, out_result, out_carry, out_err
  );

  modport slave (
    input  in_valid, in_op, in_a, in_b, out_ready,
    output in_ready, out_valid, out_result, out_carry, out_err
  );

endinterface

// File: rtl/alu_issue_seq.sv
// ALU issue/sequencing stage. Accepts one request at a time, drives the shared
// external ALU and returns the captured result. MUL is done as WIDTH rounds of
// shift-add on the same ALU.
// Ports:
//   clk, rst_n  : clock, asynchronous active-low reset
//   bus         : request/response handshake (slave modport)
//   alu_a/alu_b : operands to the ALU (0 outside EXEC/MUL)
//   alu_select  : ALU function select (0 outside EXEC/MUL)
//   alu_y       : combinational ALU result, WIDTH+1 bits including carry
module alu_issue_seq
  import alu_issue_seq_pkg::*;
#(
  parameter int WIDTH = 8
) (
  input  logic               clk,
  input  logic               rst_n,
  alu_issue_seq_if.slave     bus,
  output logic [WIDTH-1:0]   alu_a,
  output logic [WIDTH-1:0]   alu_b,
  output logic [2:0]         alu_select,
  input  logic [WIDTH:0]     alu_y
);

  localparam int CW = $clog2(WIDTH + 1);
  localparam logic [CW-1:0] LAST_ITER = CW'(WIDTH - 1);

  state_e               state_q, state_d;
  logic [3:0]           op_q, op_d;
  logic [WIDTH-1:0]     a_q, a_d;        // operand A / multiplicand
  logic [WIDTH-1:0]     acc_hi_q, acc_hi_d;
  logic [WIDTH-1:0]     mpl_q, mpl_d;    // operand B; low product half during MUL
  logic [CW-1:0]        count_q, count_d;
  logic [2*WIDTH-1:0]   result_q, result_d;
  logic                 carry_q, carry_d;
  logic                 err_q, err_d;

  assign bus.in_ready   = (state_q == IDLE);
  assign bus.out_valid  = (state_q == DONE);
  assign bus.out_result = result_q;
  assign bus.out_carry  = carry_q;
  assign bus.out_err    = err_q;

  always_comb begin
    // NOTE: every signal written here gets a default first, so no path leaves
    // one unassigned and no latch is inferred.
    state_d    = state_q;
    op_d       = op_q;
    a_d        = a_q;
    acc_hi_d   = acc_hi_q;
    mpl_d      = mpl_q;
    count_d    = count_q;
    result_d   = result_q;
    carry_d    = carry_q;
    err_d      = err_q;
    alu_a      = '0;
    alu_b      = '0;
    alu_select = SEL_PASSA;

    unique case (state_q)
      IDLE: begin
        if (bus.in_valid) begin
          op_d     = bus.in_op;
          a_d      = bus.in_a;
          mpl_d    = bus.in_b;
          acc_hi_d = '0;
          count_d  = '0;
          state_d  = (bus.in_op == OP_MUL) ? MUL : EXEC;
        end
      end

      EXEC: begin
        alu_a   = a_q;
        alu_b   = mpl_q;
        state_d = DONE;
        if (is_reserved(op_q)) begin
          result_d = '0;
          carry_d  = 1'b0;
          err_d    = 1'b1;
        end else begin
          alu_select = op_q[2:0];
          result_d   = {{WIDTH{1'b0}}, alu_y[WIDTH-1:0]};
          carry_d    = alu_y[WIDTH];
          err_d      = 1'b0;
        end
      end

      MUL: begin
        alu_a      = acc_hi_q;
        alu_b      = a_q;
        alu_select = mpl_q[0] ? SEL_ADD : SEL_PASSA;
        // The ALU sum (with its carry) replaces acc_hi and the whole
        // {sum, multiplier} word shifts right one place, so the carry lands in
        // the top bit of acc_hi and the consumed multiplier bit drops out.
        {acc_hi_d, mpl_d} = {alu_y, mpl_q[WIDTH-1:1]};
        count_d = count_q + CW'(1);
        if (count_q == LAST_ITER) begin
          result_d = {acc_hi_d, mpl_d};
          carry_d  = 1'b0;
          err_d    = 1'b0;
          state_d  = DONE;
        end
      end

      DONE: begin
        if (bus.out_ready) state_d = IDLE;
      end

      default: state_d = IDLE;
    endcase
  end

  // NOTE: sequential state uses non-blocking assignments so every flop samples
  // the values from before the edge, independent of statement order.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q  <= IDLE;
      op_q     <= '0;
      a_q      <= '0;
      acc_hi_q <= '0;
      mpl_q    <= '0;
      count_q  <= '0;
      result_q <= '0;
      carry_q  <= 1'b0;
      err_q    <= 1'b0;
    end else begin
      state_q  <= state_d;
      op_q     <= op_d;
      a_q      <= a_d;
      acc_hi_q <= acc_hi_d;
      mpl_q    <= mpl_d;
      count_q  <= count_d;
      result_q <= result_d;
      carry_q  <= carry_d;
      err_q    <= err_d;
    end
  end

endmodule

// File: tb/tb_alu_issue_seq.sv
// Self-checking bench for alu_issue_seq (WIDTH=8) with a behavioural ALU on
// the alu_* ports. Expected results come from plain arithmetic per opcode
// (a*b for MUL), independent of the sequencer's internal shift-add.
module tb_alu_issue_seq;
  localparam int W = 8;

  logic         clk;
  logic         rst_n;
  logic [W-1:0] alu_a;
  logic [W-1:0] alu_b;
  logic [2:0]   alu_select;
  logic [W:0]   alu_y;

  int n_checks;
  int n_errors;

  // Request offered during a backpressure hold (must not be taken early).
  logic         bp_req;
  logic [3:0]   bp_op;
  logic [W-1:0] bp_a;
  logic [W-1:0] bp_b;

  alu_issue_seq_if #(.WIDTH(W)) bus ();

  // Datapath ALU: results wrap modulo 2^(W+1), bit W is the carry/borrow.
  function automatic logic [W:0] alu_fn(input logic [2:0] sel, input logic [W-1:0] a,
                                        input logic [W-1:0] b);
    logic [W:0] ea, eb;
    ea = {1'b0, a};
    eb = {1'b0, b};
    case (sel)
      3'd0:    return ea;
      3'd1:    return ea + 1'b1;
      3'd2:    return ea + eb;
      3'd3:    return ea - eb;
      3'd4:    return ea & eb;
      3'd5:    return ea | eb;
      3'd6:    return ea - 1'b1;
      default: return eb;
    endcase
  endfunction

  assign alu_y = alu_fn(alu_select, alu_a, alu_b);

  alu_issue_seq #(.WIDTH(W)) dut (
    .clk        (clk),
    .rst_n      (rst_n),
    .bus        (bus),
    .alu_a      (alu_a),
    .alu_b      (alu_b),
    .alu_select (alu_select),
    .alu_y      (alu_y)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  initial begin
    #1ms;
    $display("FAIL watchdog: simulation did not reach its summary");
    $fatal(1);
  end

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_errors++;
      $display("FAIL %s: got 0x%0h expected 0x%0h", tag, got, exp);
    end
  endtask

  // Reference: result/carry/err and the number of rising edges between the
  // acceptance edge and out_valid first reading 1. Accepting in cycle N means
  // valid in cycle N+2 (ALU op: 1 edge later) or N+1+W (MUL: W edges later).
  task automatic ref_model(input logic [3:0] op, input logic [W-1:0] a, input logic [W-1:0] b,
                           output logic [2*W-1:0] res, output logic c, output logic e,
                           output int lat);
    logic [W:0] y;
    if (op == 4'b1000) begin
      res = (2*W)'(a) * (2*W)'(b);
      c = 1'b0; e = 1'b0; lat = W;
    end else if (op[3]) begin
      res = '0; c = 1'b0; e = 1'b1; lat = 1;
    end else begin
      y = alu_fn(op[2:0], a, b);
      res = {{W{1'b0}}, y[W-1:0]};
      c = y[W]; e = 1'b0; lat = 1;
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic check_idle_outputs(input string tag);
    check({tag, " in_ready"},   32'(bus.in_ready),   32'd1);
    check({tag, " out_valid"},  32'(bus.out_valid),  32'd0);
    check({tag, " out_result"}, 32'(bus.out_result), 32'd0);
    check({tag, " out_carry"},  32'(bus.out_carry),  32'd0);
    check({tag, " out_err"},    32'(bus.out_err),    32'd0);
    check({tag, " alu_a"},      32'(alu_a),          32'd0);
    check({tag, " alu_b"},      32'(alu_b),          32'd0);
    check({tag, " alu_select"}, 32'(alu_select),     32'd0);
  endtask

  // One full transaction: offer, accept, wait for result, hold `hold` cycles
  // with out_ready=0, then complete the output handshake.
  task automatic do_op(input string tag, input logic [3:0] op, input logic [W-1:0] a,
                       input logic [W-1:0] b, input int hold);
    logic [2*W-1:0] exp_res;
    logic           exp_c, exp_e;
    int             exp_lat, lat;
    ref_model(op, a, b, exp_res, exp_c, exp_e, exp_lat);

    lat = 0;
    while (!bus.in_ready && lat < 50) begin
      tick();
      lat++;
    end
    check({tag, " in_ready before accept"}, 32'(bus.in_ready), 32'd1);

    bus.in_valid = 1'b1;
    bus.in_op    = op;
    bus.in_a     = a;
    bus.in_b     = b;
    tick();
    // Operands must have been registered; scramble the inputs afterwards.
    bus.in_valid = 1'b0;
    bus.in_op    = 4'($urandom);
    bus.in_a     = W'($urandom);
    bus.in_b     = W'($urandom);
    check({tag, " in_ready busy"}, 32'(bus.in_ready), 32'd0);

    lat = 0;
    while (!bus.out_valid && lat < 40) begin
      tick();
      lat++;
    end
    check({tag, " latency"}, 32'(lat), 32'(exp_lat));

    for (int i = 0; i < hold; i++) begin
      if (bp_req) begin
        bus.in_valid = 1'b1;
        bus.in_op    = bp_op;
        bus.in_a     = bp_a;
        bus.in_b     = bp_b;
      end
      check({tag, " held result"}, 32'(bus.out_result), 32'(exp_res));
      check({tag, " held in_ready"}, 32'(bus.in_ready), 32'd0);
      tick();
    end

    check({tag, " out_valid"}, 32'(bus.out_valid),  32'd1);
    check({tag, " result"},    32'(bus.out_result), 32'(exp_res));
    check({tag, " carry"},     32'(bus.out_carry),  32'(exp_c));
    check({tag, " err"},       32'(bus.out_err),    32'(exp_e));
    check({tag, " alu drive in DONE"}, {alu_select, 8'(alu_a), 8'(alu_b)}, 32'd0);

    bus.out_ready = 1'b1;
    tick();
    bus.out_ready = 1'b0;
    check({tag, " out_valid cleared"}, 32'(bus.out_valid), 32'd0);
    check({tag, " in_ready after"},    32'(bus.in_ready),  32'd1);
  endtask

  initial begin
    n_checks      = 0;
    n_errors      = 0;
    bp_req        = 1'b0;
    bp_op         = '0;
    bp_a          = '0;
    bp_b          = '0;
    rst_n         = 1'b0;
    bus.in_valid  = 1'b0;
    bus.in_op     = '0;
    bus.in_a      = '0;
    bus.in_b      = '0;
    bus.out_ready = 1'b0;

    // Reset state, while reset is still held.
    repeat (3) tick();
    check_idle_outputs("reset");
    rst_n = 1'b1;
    tick();

    // Directed cases.
    do_op("add_0f_01",  4'b0010, 8'h0F, 8'h01, 0);
    do_op("add_ff_01",  4'b0010, 8'hFF, 8'h01, 1);
    do_op("dec_00",     4'b0110, 8'h00, 8'h5A, 0);
    do_op("mul_13_11",  4'b1000, 8'd13, 8'd11, 0);
    do_op("mul_ff_ff",  4'b1000, 8'hFF, 8'hFF, 0);
    do_op("mul_0_x",    4'b1000, 8'h00, 8'hA7, 0);

    // Backpressure with a new request waiting for the whole hold.
    bp_req = 1'b1;
    bp_op  = 4'b0010;
    bp_a   = 8'h22;
    bp_b   = 8'h33;
    do_op("bp_mul", 4'b1000, 8'd7, 8'd9, 5);
    bp_req = 1'b0;
    check("bp pending still offered", 32'(bus.in_valid), 32'd1);
    do_op("bp_next_add", 4'b0010, 8'h22, 8'h33, 0);

    // Asynchronous reset at MUL iteration 4.
    bus.in_valid = 1'b1;
    bus.in_op    = 4'b1000;
    bus.in_a     = 8'hFF;
    bus.in_b     = 8'hFF;
    tick();
    bus.in_valid = 1'b0;
    repeat (3) tick();
    check("mid-mul alu_a nonzero", 32'(alu_a != '0), 32'd1);
    #2;
    rst_n = 1'b0;
    #1;
    check_idle_outputs("async reset");
    tick();
    rst_n = 1'b1;
    tick();
    do_op("post_reset_add", 4'b0010, 8'h40, 8'h05, 0);

    // Reserved opcode, then an ordinary op must clear err.
    do_op("reserved_1011", 4'b1011, 8'h12, 8'h34, 0);
    do_op("after_reserved", 4'b0011, 8'h05, 8'h09, 0);

    // Randomized traffic; MUL and reserved opcodes are drawn often.
    for (int i = 0; i < 40; i++) begin
      logic [3:0] op;
      int         pick;
      pick = int'($urandom_range(0, 9));
      if (pick < 3)       op = 4'b1000;
      else if (pick == 3) op = 4'($urandom_range(9, 15));
      else                op = 4'($urandom_range(0, 7));
      do_op($sformatf("rand%0d_op%0h", i, op), op, W'($urandom), W'($urandom),
            int'($urandom_range(0, 3)));
    end

    $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
    $finish;
  end

endmodule
